// File: rtl/demux16_capture.sv
// Serial bit-lane demultiplexer: steers 1-bit samples into a 16-bit word and hands it off on valid/ready.
// Optional sticky duplicate-lane flag on port dup_err when DEMUX16_DUP_ERR_EN is defined.
module demux16_capture #(
    parameter logic [15:0] RESET_DATA = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic [3:0]  sel,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] data_out,
    output logic [15:0] filled,
    output logic        out_valid,
    input  logic        out_ready
`ifdef DEMUX16_DUP_ERR_EN
    ,
    output logic        dup_err
`endif
);

    localparam int unsigned WORD_W = 16;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]        state_q,  state_d;
    logic [WORD_W-1:0] data_q,   data_d;
    logic [WORD_W-1:0] filled_q, filled_d;
`ifdef DEMUX16_DUP_ERR_EN
    logic              dup_err_q, dup_err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_COLLECT;
            data_q   <= RESET_DATA;
            filled_q <= '0;
`ifdef DEMUX16_DUP_ERR_EN
            dup_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            filled_q <= filled_d;
`ifdef DEMUX16_DUP_ERR_EN
            dup_err_q <= dup_err_d;
`endif
        end
    end

    // Next-state: collect lanes until every bit is marked, then hold until popped.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        filled_d = filled_q;
`ifdef DEMUX16_DUP_ERR_EN
        dup_err_d = dup_err_q;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (din_valid) begin
                    data_d[sel]   = din;
                    filled_d[sel] = 1'b1;
`ifdef DEMUX16_DUP_ERR_EN
                    if (filled_q[sel]) begin
                        dup_err_d = 1'b1;
                    end
`endif
                    if (filled_d == '1) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    data_d   = RESET_DATA;
                    filled_d = '0;
                    state_d  = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign data_out  = data_q;
    assign filled    = filled_q;
    assign out_valid = (state_q == ST_HOLD);
    assign din_ready = (state_q == ST_COLLECT);
`ifdef DEMUX16_DUP_ERR_EN
    assign dup_err   = dup_err_q;
`endif

endmodule

// File: tb/tb_demux16_capture.sv
// Self-checking bench for demux16_capture: vector table, directed corner sequences and a random run
// against a lane-array reference model.
module tb_demux16_capture;

    localparam logic [15:0] RST_WORD = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic [3:0]  sel;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] data_out;
    logic [15:0] filled;
    logic        out_valid;
    logic        out_ready;
`ifdef DEMUX16_DUP_ERR_EN
    logic        dup_err;
`endif

    demux16_capture #(.RESET_DATA(RST_WORD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .data_out  (data_out),
        .filled    (filled),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX16_DUP_ERR_EN
        ,
        .dup_err   (dup_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: one bit and one written-flag per lane, plus a count of distinct lanes.
    bit m_bits[16];
    bit m_wr[16];
    int m_cnt;
    bit m_hold;
    bit m_dup;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_bits[i] = RST_WORD[i];
            m_wr[i]   = 1'b0;
        end
        m_cnt  = 0;
        m_hold = 1'b0;
        m_dup  = 1'b0;
    endtask

    function automatic logic [15:0] m_word();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = m_bits[i];
        return w;
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = m_wr[i];
        return w;
    endfunction

    task automatic m_step();
        int lane;
        lane = int'(sel);
        if (!m_hold) begin
            if (din_valid) begin
                m_bits[lane] = din;
                if (m_wr[lane]) begin
                    m_dup = 1'b1;
                end else begin
                    m_wr[lane] = 1'b1;
                    m_cnt++;
                end
                if (m_cnt == 16) m_hold = 1'b1;
            end
        end else if (out_ready) begin
            for (int i = 0; i < 16; i++) begin
                m_bits[i] = RST_WORD[i];
                m_wr[i]   = 1'b0;
            end
            m_cnt  = 0;
            m_hold = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("data_out", data_out, m_word());
        chk("filled", filled, m_mask());
        chk("out_valid", 16'(out_valid), 16'(m_hold));
        chk("din_ready", 16'(din_ready), 16'(!m_hold));
`ifdef DEMUX16_DUP_ERR_EN
        chk("dup_err", 16'(dup_err), 16'(m_dup));
`endif
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge after checking.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) m_step();
        else       m_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic d, input logic [3:0] s, input logic r);
        din_valid = v;
        din       = d;
        sel       = s;
        out_ready = r;
    endtask

    typedef struct {
        logic        din;
        logic [3:0]  sel;
        logic        din_valid;
        logic        out_ready;
        logic [15:0] exp_data;
        logic [15:0] exp_filled;
        logic        exp_out_valid;
        logic        exp_din_ready;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [15:0] pat;
        logic [15:0] words[2];
        logic [15:0] w;
        logic [15:0] popped[$];
        int          idx;
        int          stalls;
        int          budget;
        bit          accepted;

        // In-order 16'hAAAA fill with out_ready high, then the pop cycle.
        pat = 16'hAAAA;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] mk;
            mk = (i == 15) ? 16'hFFFF : 16'((32'd1 << (i + 1)) - 1);
            vecs[i].din           = pat[i];
            vecs[i].sel           = 4'(i);
            vecs[i].din_valid     = 1'b1;
            vecs[i].out_ready     = 1'b1;
            vecs[i].exp_data      = (pat & mk) | (RST_WORD & ~mk);
            vecs[i].exp_filled    = mk;
            vecs[i].exp_out_valid = (i == 15);
            vecs[i].exp_din_ready = (i != 15);
        end
        vecs[16] = '{din: 1'b0, sel: 4'd0, din_valid: 1'b0, out_ready: 1'b1,
                     exp_data: RST_WORD, exp_filled: 16'h0000,
                     exp_out_valid: 1'b0, exp_din_ready: 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        m_reset();
        #1;
        chk("reset_data", data_out, RST_WORD);
        chk("reset_filled", filled, 16'h0000);
        chk("reset_out_valid", 16'(out_valid), 16'd0);
        chk("reset_din_ready", 16'(din_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].din_valid, vecs[i].din, vecs[i].sel, vecs[i].out_ready);
            cycle();
            chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            chk($sformatf("vec%0d_filled", i), filled, vecs[i].exp_filled);
            chk($sformatf("vec%0d_out_valid", i), 16'(out_valid), 16'(vecs[i].exp_out_valid));
            chk($sformatf("vec%0d_din_ready", i), 16'(din_ready), 16'(vecs[i].exp_din_ready));
        end

        // Reset mid-word with lanes 0..7 written.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 4'(i), 1'b0);
            cycle();
        end
        chk("midword_filled", filled, 16'h00FF);
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", data_out, RST_WORD);
        chk("async_rst_filled", filled, 16'h0000);
        chk("async_rst_out_valid", 16'(out_valid), 16'd0);
        chk("async_rst_din_ready", 16'(din_ready), 16'd1);
        m_reset();
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Reverse order 16'h5A3C with backpressure and ignored writes during hold.
        pat = 16'h5A3C;
        for (int i = 15; i >= 0; i--) begin
            drive(1'b1, pat[i], 4'(i), 1'b0);
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
            cycle();
            chk("hold_data", data_out, 16'h5A3C);
            chk("hold_din_ready", 16'(din_ready), 16'd0);
            chk("hold_out_valid", 16'(out_valid), 16'd1);
        end
        drive(1'b1, 1'b1, 4'd0, 1'b1);
        cycle();
        chk("pop_out_valid", 16'(out_valid), 16'd0);
        chk("pop_filled", filled, 16'h0000);

        // Duplicate write to lane 3, then the other 15 lanes.
        drive(1'b1, 1'b1, 4'd3, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 4'd3, 1'b0);
        cycle();
        chk("dup_filled", filled, 16'h0008);
`ifdef DEMUX16_DUP_ERR_EN
        chk("dup_err_set", 16'(dup_err), 16'd1);
`endif
        for (int i = 0; i < 16; i++) begin
            if (i == 3) continue;
            drive(1'b1, 1'b1, 4'(i), 1'b0);
            cycle();
            chk("dup_complete_timing", 16'(out_valid), 16'(i == 15));
        end
        chk("dup_word", data_out, 16'hFFF7);
        drive(1'b0, 1'b0, 4'd0, 1'b1);
        cycle();
`ifdef DEMUX16_DUP_ERR_EN
        chk("dup_err_sticky", 16'(dup_err), 16'd1);
`endif

        // Back-to-back words with din_valid held high and out_ready high.
        words[0] = 16'h1234;
        words[1] = 16'hFEDC;
        idx      = 0;
        stalls   = 0;
        budget   = 0;
        while (popped.size() < 2 && budget < 100) begin
            if (idx < 32) begin
                w = words[idx / 16];
                drive(1'b1, w[idx % 16], 4'(idx % 16), 1'b1);
            end else begin
                drive(1'b0, 1'b0, 4'd0, 1'b1);
            end
            accepted = din_ready && (idx < 32);
            if (out_valid) popped.push_back(data_out);
            cycle();
            if (accepted) idx++;
            if (!din_ready && idx >= 16 && idx < 32) stalls++;
            budget++;
        end
        chk("b2b_budget", 16'(budget < 100), 16'd1);
        chk("b2b_count", 16'(popped.size()), 16'd2);
        if (popped.size() >= 1) chk("b2b_word0", popped[0], 16'h1234);
        if (popped.size() >= 2) chk("b2b_word1", popped[1], 16'hFEDC);
        chk("b2b_stalls", 16'(stalls), 16'd1);

        // Random traffic against the model, with an occasional reset.
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
            if (k == 300) rst_n = 1'b0;
            if (k == 302) rst_n = 1'b1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux16_capture.md
# demux16_capture

Sequential 1-to-16 demultiplexer and word assembler: the inverse of the 16:1 bit-select mux. Single-bit samples arrive with a 4-bit lane select and are steered into the addressed bit of a 16-bit holding register. When all 16 lanes have been written, the assembled word is presented on a valid/ready output handshake. The block sits on the receive side of any path that serialises a 16-bit word through `mux16to1` and rebuilds it downstream.

## Interface
- `RESET_DATA`, default 16'h0000: value loaded into `data_out` on reset and after each accepted pop.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `din` input 1: sample bit to store.
- `sel` input 4: destination lane (bit index) for `din`.
- `din_valid` input 1: `din`/`sel` are valid this cycle.
- `din_ready` output 1: block accepts a sample this cycle.
- `data_out` output 16: assembled word; bit *k* = last `din` written with `sel`=*k*.
- `filled` output 16: lane-written mask for the word in progress.
- `out_valid` output 1: `data_out` is a complete word.
- `out_ready` input 1: downstream consumes the word.
- `dup_err` output 1: sticky duplicate-write flag; present only with the macro below.

## Operation
- Write accepted when `din_valid && din_ready`. On the next edge: `data_out[sel] <= din` and `filled[sel] <= 1`. Other bits are unchanged.
- State COLLECT:
  - `din_ready`=1, `out_valid`=0.
  - On an accepted write that makes `filled` all-ones (including the write itself), go to HOLD.
- State HOLD:
  - `din_ready`=0, `out_valid`=1, `data_out` frozen.
  - On `out_valid && out_ready`: `filled` <= 0, `data_out` <= `RESET_DATA`, go to COLLECT.
- Duplicate write: a write to a lane whose `filled` bit is already 1 overwrites the data bit. `filled` is unchanged and does not advance completion.
- Lanes may be written in any order; sel order 0..15 is not required.
- `din_valid` in HOLD is ignored. No sample is stored or lost-flagged; the upstream must hold it until `din_ready`.
- `out_ready` in COLLECT is ignored.
- Reset values:
  - `data_out`=`RESET_DATA`, `filled`=0, `out_valid`=0, `din_ready`=1, `dup_err`=0.
  - State=COLLECT.
- Reset asserted mid-word or in HOLD discards all partial/complete data immediately (asynchronous). No word is emitted.

## Timing
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- The 16th distinct write at edge N causes `out_valid`=1 and `din_ready`=0 from edge N.
- Pop at edge M (`out_valid && out_ready` sampled high) causes `out_valid`=0 and `din_ready`=1 after edge M. The earliest next accepted write is at edge M+1, so there is a 1-cycle turnaround with no bypass.
- Minimum word period is 17 cycles: 16 writes plus 1 pop. If `out_ready` is held high, a word completed at edge N pops at edge N+1.
- `data_out` is stable for the whole time `out_valid`=1.

## Configuration
- `DEMUX16_DUP_ERR_EN` defined:
  - `dup_err` port exists.
  - It sets on any accepted write whose lane is already filled.
  - It clears only on reset; it is not cleared by a pop.
- Not defined: the `dup_err` port and its logic are absent. Duplicate writes silently overwrite, as described under Operation.

## Test plan
- **Reset:** drive `rst_n`=0 mid-word (`filled`=16'h00FF). All outputs return to reset values within the same cycle. `out_valid` never rises.
- **In-order fill:** `din` = bits of 16'hAAAA, `sel` 0..15 on consecutive cycles, `out_ready`=1.
  - `out_valid`=1 for exactly one cycle with `data_out`=16'hAAAA.
  - `filled`=0 and `din_ready`=1 afterwards.
- **Reverse/random order with backpressure:** write 16'h5A3C with `sel` 15..0 and `out_ready`=0 for 5 cycles.
  - `data_out` holds 16'h5A3C and `din_ready`=0 throughout.
  - `din_valid` pulses during HOLD are not stored.
- **Duplicate write:** write lane 3 = 1, then lane 3 = 0, then the remaining 15 lanes = 1.
  - Result is 16'hFFF7.
  - Completion occurs only after the 16th distinct lane is written.
  - With `DEMUX16_DUP_ERR_EN`, `dup_err`=1 from the second write onward and remains 1 after the pop.
- **Back-to-back words:** two words 16'h1234 then 16'hFEDC, with `din_valid` held high and `out_ready`=1.
  - Both are received intact.
  - There is exactly one `din_ready`=0 cycle between them.
